// File: rtl/random_delay_gen.sv
// random_delay_gen: waits a pseudo-random number of ms after a start edge, then lights the stimulus LED
module random_delay_gen #(
    parameter int          CLK_DIV    = 50000,
    parameter int          MIN_MS     = 1000,
    parameter int          RANGE_BITS = 12,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        led,
    output logic        lit_pulse,
    output logic        busy,
    output logic [12:0] delay_ms
);
    localparam int PW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE, WAIT, LIT} state_t;
    state_t          state;
    logic            start_q;
    logic [PW-1:0]   prescaler;
    logic [12:0]     ms_cnt;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic            start_rise;
    logic            tick;
    // an all-zero LFSR would lock up, so kick it back to a nonzero state
    assign lfsr_next  = lfsr == 16'h0 ? 16'h0001 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign start_rise = start & ~start_q;
    assign tick       = prescaler == PW'(CLK_DIV - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            led       <= 1'b0;
            lit_pulse <= 1'b0;
            busy      <= 1'b0;
            delay_ms  <= '0;
            start_q   <= 1'b0;
            prescaler <= '0;
            ms_cnt    <= '0;
            lfsr      <= LFSR_SEED;
        end else begin
            start_q   <= start;
            lfsr      <= lfsr_next;
            lit_pulse <= 1'b0;
            if (start_rise) begin
                state     <= WAIT;
                busy      <= 1'b1;
                led       <= 1'b0;
                prescaler <= '0;
                ms_cnt    <= '0;
                delay_ms  <= 13'(MIN_MS) + 13'(lfsr[RANGE_BITS-1:0]);
            end else if (state == WAIT) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick) begin
                    ms_cnt <= ms_cnt + 13'd1;
                    if (ms_cnt == delay_ms - 13'd1) begin
                        state     <= LIT;
                        led       <= 1'b1;
                        lit_pulse <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
